aes_key_sched_ctrl: RTL and testbench

Sequencer for the combinational AES-128 round-key generator (start/rc/key in; finished/keyout out). It accepts a 128-bit cipher key over a valid/ready handshake and steps the generator through rounds rc=0..9, each round fed the previous round's output. It stores all 11 round keys (rk0 = cipher key, rk1..rk10) and serves them to the cipher datapath through an indexed, registered read port. It sits between the AES register front-end and the round datapath.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_key_sched_ctrl_if.sv | 35 +++
 rtl/aes_rk_store.sv | 35 +++
 rtl/aes_key_sched_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and widths for the AES-128 key-schedule sequencer.
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int NUM_RK    = 11;
  localparam int RC_W      = 4;

  typedef enum logic [2:0] {
    KS_IDLE  = 3'd0,
    KS_START = 3'd1,
    KS_WAIT  = 3'd2,
    KS_STORE = 3'd3,
    KS_DONE  = 3'd4,
    KS_ERR   = 3'd5
  } ks_state_e;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key handshake, round-key generator link and round-key read port of the sequencer.
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic                 key_valid_i;
  logic                 key_ready_o;
  logic [AES_KEY_W-1:0] key_i;
  logic                 abort_i;
  logic                 kg_start_o;
  logic [RC_W-1:0]      kg_rc_o;
  logic [AES_KEY_W-1:0] kg_key_o;
  logic                 kg_finished_i;
  logic [AES_KEY_W-1:0] kg_keyout_i;
  logic [RC_W-1:0]      rk_idx_i;
  logic [AES_KEY_W-1:0] rk_o;
  logic                 rk_valid_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  // Controller side.
  modport slave (
    input  key_valid_i, key_i, abort_i, kg_finished_i, kg_keyout_i, rk_idx_i,
    output key_ready_o, kg_start_o, kg_rc_o, kg_key_o, rk_o, rk_valid_o,
    output busy_o, done_o, err_o
  );

  // Front-end / generator / datapath side.
  modport master (
    output key_valid_i, key_i, abort_i, kg_finished_i, kg_keyout_i, rk_idx_i,
    input  key_ready_o, kg_start_o, kg_rc_o, kg_key_o, rk_o, rk_valid_o,
    input  busy_o, done_o, err_o
  );

endinterface

// File: rtl/aes_rk_store.sv
// Round-key register file: one write port, one registered read port (out-of-range reads give 0).
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int DEPTH = NUM_RK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [RC_W-1:0]      waddr,
  input  logic [AES_KEY_W-1:0] wdata,
  input  logic [RC_W-1:0]      raddr,
  output logic [AES_KEY_W-1:0] rdata
);

  logic [AES_KEY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle write and read of one index returns the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (int'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Steps the combinational AES-128 round-key generator through all rounds and
// keeps every round key for indexed readout by the cipher datapath.
//
// state | meaning
// IDLE  | ready for a cipher key
// START | raise start to the generator, clear wait timer
// WAIT  | hold start until generator finishes or the timer expires
// STORE | drop start one cycle so the sboxes re-arm, advance round
// DONE  | all round keys stored, pulse done
// ERR   | generator timeout, set sticky error
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int WAIT_MAX   = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_key_sched_ctrl_if.slave bus
);

  localparam int WC_W = $clog2(WAIT_MAX);
  localparam logic [RC_W-1:0] LAST_RC   = RC_W'(NUM_ROUNDS - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  ks_state_e            state, state_nx;
  logic [RC_W-1:0]      rc;
  logic [WC_W-1:0]      wait_cnt;
  logic [AES_KEY_W-1:0] cur_key;
  logic                 rk_valid;
  logic                 err;
  logic                 abort_act, accept, kg_hit;
  logic                 rk_we;
  logic [RC_W-1:0]      rk_waddr;
  logic [AES_KEY_W-1:0] rk_wdata, rk_rdata;
  logic                 key_ready, kg_start, busy, done;

  assign abort_act = bus.abort_i && (state != KS_IDLE);
  assign accept    = (state == KS_IDLE) && bus.key_valid_i;
  assign kg_hit    = (state == KS_WAIT) && bus.kg_finished_i && !bus.abort_i;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= KS_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      KS_IDLE:  if (bus.key_valid_i) state_nx = KS_START;
      KS_START: state_nx = KS_WAIT;
      KS_WAIT: begin
        if (bus.kg_finished_i)        state_nx = KS_STORE;
        else if (wait_cnt == WAIT_LAST) state_nx = KS_ERR;
      end
      KS_STORE: state_nx = (rc == LAST_RC) ? KS_DONE : KS_START;
      KS_DONE:  state_nx = KS_IDLE;
      KS_ERR:   state_nx = KS_IDLE;
      default:  state_nx = KS_IDLE;
    endcase
    // Abort wins over a finishing generator in the same cycle.
    if (abort_act) state_nx = KS_IDLE;
  end

  always_comb begin
    key_ready = 1'b0;
    kg_start  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      KS_IDLE:  key_ready = 1'b1;
      KS_START: begin kg_start = 1'b1; busy = 1'b1; end
      KS_WAIT:  begin kg_start = 1'b1; busy = 1'b1; end
      KS_STORE: busy = 1'b1;
      KS_DONE:  done = !bus.abort_i;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc       <= '0;
      wait_cnt <= '0;
      cur_key  <= '0;
      rk_valid <= 1'b0;
      err      <= 1'b0;
    end else if (abort_act) begin
      rk_valid <= 1'b0;
    end else begin
      case (state)
        KS_IDLE: if (bus.key_valid_i) begin
          cur_key  <= bus.key_i;
          rc       <= '0;
          rk_valid <= 1'b0;
          err      <= 1'b0;
        end
        KS_START: wait_cnt <= '0;
        KS_WAIT: begin
          if (bus.kg_finished_i)          cur_key  <= bus.kg_keyout_i;
          else if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + WC_W'(1);
        end
        KS_STORE: if (rc != LAST_RC) rc <= rc + RC_W'(1);
        KS_DONE:  rk_valid <= 1'b1;
        KS_ERR:   err <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign rk_we    = accept || kg_hit;
  assign rk_waddr = accept ? '0 : rc + RC_W'(1);
  assign rk_wdata = accept ? bus.key_i : bus.kg_keyout_i;

  aes_rk_store #(
    .DEPTH (NUM_ROUNDS + 1)
  ) u_rk_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rk_we),
    .waddr (rk_waddr),
    .wdata (rk_wdata),
    .raddr (bus.rk_idx_i),
    .rdata (rk_rdata)
  );

  assign bus.key_ready_o = key_ready;
  assign bus.kg_start_o  = kg_start;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.kg_rc_o     = rc;
  assign bus.kg_key_o    = cur_key;
  assign bus.rk_valid_o  = rk_valid;
  assign bus.err_o       = err;
  assign bus.rk_o        = rk_rdata;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 generator with per-round
// finish delays, key-expansion reference model and cycle-count expectations.
module tb_aes_key_sched_ctrl;

  logic clk;
  logic rst_n;
  aes_key_sched_ctrl_if bus();

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  int           total = 0;
  int           bad   = 0;
  int           dly [16];
  bit           hang;
  int           start_cnt;
  logic [127:0] mrk [0:10];
  rd_vec_t      vec [16];
  int           rises, gaps, maxgap, rc_ok;

  // ---------------- AES-128 round model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, e;
    r = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < int'(rc); i++) r = r[7] ? ((r << 1) ^ 8'h1b) : (r << 1);
    return r;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    {w0, w1, w2, w3} = k;
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon(rc), 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Generator stub: finishes once start has been high for dly[rc] earlier cycles.
  always @(posedge clk) start_cnt <= bus.kg_start_o ? start_cnt + 1 : 0;
  assign bus.kg_finished_i = !hang && bus.kg_start_o && (start_cnt >= dly[bus.kg_rc_o]);
  assign bus.kg_keyout_i   = aes_round(bus.kg_key_o, bus.kg_rc_o);

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expand(input logic [127:0] k);
    mrk[0] = k;
    for (int r = 0; r < 10; r++) mrk[r+1] = aes_round(mrk[r], 4'(r));
  endtask

  function automatic int exp_done();
    int e;
    e = 1;
    for (int r = 0; r < 10; r++) e += dly[r] + 2;
    return e;
  endfunction

  // Present a key in the current (IDLE) cycle; return the cycle number of done_o, or -1.
  task automatic run_key(input logic [127:0] k, output int dcyc);
    int   n, run;
    logic prev_start;
    bus.key_i = k;
    bus.key_valid_i = 1'b1;
    step();
    bus.key_valid_i = 1'b0;
    n = 1; dcyc = -1; rises = 0; gaps = 0; maxgap = 0; run = 0; rc_ok = 1; prev_start = 1'b0;
    while (n < 2000 && dcyc < 0) begin
      if (bus.kg_start_o && !prev_start) begin
        if (bus.kg_rc_o != 4'(rises)) rc_ok = 0;
        rises++;
      end
      if (bus.busy_o && !bus.kg_start_o) begin
        run++; gaps++;
        if (run > maxgap) maxgap = run;
      end else run = 0;
      prev_start = bus.kg_start_o;
      if (bus.done_o) dcyc = n;
      else begin step(); n++; end
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      vec[i].idx = 4'(i);
      vec[i].exp = (i <= 10) ? mrk[i] : '0;
    end
    for (int i = 0; i < 16; i++) begin
      bus.rk_idx_i = vec[i].idx;
      step();
      chk($sformatf("%s rk[%0d]", tag, i), bus.rk_o, vec[i].exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " key_ready"}, 128'(bus.key_ready_o), 128'(1));
    chk({tag, " busy"},      128'(bus.busy_o),      128'(0));
    chk({tag, " kg_start"},  128'(bus.kg_start_o),  128'(0));
    chk({tag, " done"},      128'(bus.done_o),      128'(0));
    chk({tag, " err"},       128'(bus.err_o),       128'(0));
    chk({tag, " rk_valid"},  128'(bus.rk_valid_o),  128'(0));
    chk({tag, " kg_rc"},     128'(bus.kg_rc_o),     128'(0));
    chk({tag, " kg_key"},    bus.kg_key_o,          128'(0));
    chk({tag, " rk_o"},      bus.rk_o,              128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] key, saved6;
    int           dc, n;

    for (int i = 0; i < 16; i++) dly[i] = 1;
    hang = 1'b0;
    rst_n = 1'b0;
    bus.key_valid_i = 1'b0;
    bus.key_i = '0;
    bus.abort_i = 1'b0;
    bus.rk_idx_i = '0;
    step();
    step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();

    // FIPS-197 example key, generator finishes on first WAIT cycle
    key = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    expand(key);
    run_key(key, dc);
    chk_int("fips done cycle", dc, 31);
    step();
    chk("fips rk_valid", 128'(bus.rk_valid_o), 128'(1));
    chk("fips kg_key last", bus.kg_key_o, mrk[10]);
    bus.rk_idx_i = 4'd1;
    step();
    chk("fips rk1", bus.rk_o, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    bus.rk_idx_i = 4'd10;
    step();
    chk("fips rk10", bus.rk_o, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    sweep("fips");

    // Every round finishes four cycles after start rises
    for (int i = 0; i < 16; i++) dly[i] = 4;
    key = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    expand(key);
    run_key(key, dc);
    chk_int("slow done cycle", dc, 61);
    chk_int("slow start rises", rises, 10);
    chk_int("slow rc sequence", rc_ok, 1);
    chk_int("slow start gaps", gaps, 10);
    chk_int("slow max gap", maxgap, 1);
    step();
    chk("slow rk_valid", 128'(bus.rk_valid_o), 128'(1));

    // Generator never finishes: timeout trap
    hang = 1'b1;
    bus.key_i = 128'hdeadbeef_00112233_44556677_8899aabb;
    bus.key_valid_i = 1'b1;
    step();
    bus.key_valid_i = 1'b0;
    n = 1;
    while (!bus.key_ready_o && n < 100) begin step(); n++; end
    chk_int("hang ready cycle", n, 18);
    chk("hang err", 128'(bus.err_o), 128'(1));
    chk("hang rk_valid", 128'(bus.rk_valid_o), 128'(0));
    chk("hang key_ready", 128'(bus.key_ready_o), 128'(1));
    hang = 1'b0;
    for (int i = 0; i < 16; i++) dly[i] = 1;
    key = 128'h0f1571c9_47d9e859_0cb7add6_af7f6798;
    expand(key);
    run_key(key, dc);
    chk("hang cleared err", 128'(bus.err_o), 128'(0));
    chk_int("recover done cycle", dc, 31);
    step();
    chk("recover rk_valid", 128'(bus.rk_valid_o), 128'(1));
    saved6 = mrk[6];

    // Abort in round 5 WAIT while the generator finishes in the same cycle
    key = 128'h11223344_55667788_99aabbcc_ddeeff00;
    expand(key);
    bus.key_i = key;
    bus.key_valid_i = 1'b1;
    step();
    bus.key_valid_i = 1'b0;
    for (n = 1; n < 17; n++) step();
    chk("abort rc", 128'(bus.kg_rc_o), 128'(5));
    chk("abort finished", 128'(bus.kg_finished_i), 128'(1));
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("abort key_ready", 128'(bus.key_ready_o), 128'(1));
    chk("abort busy", 128'(bus.busy_o), 128'(0));
    chk("abort done", 128'(bus.done_o), 128'(0));
    chk("abort rk_valid", 128'(bus.rk_valid_o), 128'(0));
    bus.rk_idx_i = 4'd5;
    step();
    chk("abort rk5 new", bus.rk_o, mrk[5]);
    bus.rk_idx_i = 4'd6;
    step();
    chk("abort rk6 kept", bus.rk_o, saved6);
    chk("abort no late done", 128'(bus.done_o), 128'(0));

    // Synchronous reset mid-round 3, then a fresh key
    key = 128'hcafef00d_12345678_9abcdef0_0badc0de;
    expand(key);
    bus.key_i = key;
    bus.key_valid_i = 1'b1;
    step();
    bus.key_valid_i = 1'b0;
    for (n = 1; n < 11; n++) step();
    chk("rst mid rc", 128'(bus.kg_rc_o), 128'(3));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_outs("rst mid");
    step();
    step();
    run_key(key, dc);
    chk_int("post-rst done cycle", dc, 31);
    step();
    chk("post-rst rk_valid", 128'(bus.rk_valid_o), 128'(1));
    sweep("post-rst");

    // Randomised keys and per-round finish delays against the model
    for (int it = 0; it < 6; it++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int r = 0; r < 10; r++) dly[r] = int'($urandom_range(1, 6));
      expand(key);
      run_key(key, dc);
      chk_int($sformatf("rand%0d done cycle", it), dc, exp_done());
      step();
      chk($sformatf("rand%0d rk_valid", it), 128'(bus.rk_valid_o), 128'(1));
      for (int j = 0; j < 6; j++) begin
        n = int'($urandom_range(0, 15));
        bus.rk_idx_i = 4'(n);
        step();
        chk($sformatf("rand%0d rk[%0d]", it, n), bus.rk_o, (n <= 10) ? mrk[n] : '0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
